// File: rtl/morse_pkg.sv
// Shared Morse types, limits and the A-H letter table used by receive and transmit sides.
// Latency: n/a (types, constants and a combinational lookup function only).
// Backpressure: n/a.
//
// Table entry layout is {len[2:0], code[3:0]}; code bit i holds symbol i
// (symbol 0 = first received), 0 = dot, 1 = dash, unused code bits are 0.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MARK   = 2'd1,
    SPACE  = 2'd2,
    DECODE = 2'd3
  } state_t;

  localparam int MAX_SYMS = 4;

  // Index 0 = A ... index 7 = H; concatenation lists H first.
  localparam logic [7:0][6:0] LETTER_TABLE = {
    {3'd4, 4'b0000},  // H ....
    {3'd3, 4'b0011},  // G --.
    {3'd4, 4'b0100},  // F ..-.
    {3'd1, 4'b0000},  // E .
    {3'd3, 4'b0001},  // D -..
    {3'd4, 4'b0101},  // C -.-.
    {3'd4, 4'b0001},  // B -...
    {3'd2, 4'b0010}   // A .-
  };

  // Returns {hit, index[2:0]}; hit = 0 when no entry matches.
  function automatic logic [3:0] lookup_letter(input logic [2:0] len,
                                               input logic [3:0] code);
    logic [3:0] res;
    res = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      if (LETTER_TABLE[i] == {len, code}) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/morse_receiver_unit_timer.sv
// Time-unit timer: prescaler wrapping every UNIT_CYCLES cycles plus a saturating 3-bit unit counter.
// Latency: tick is combinational from the prescaler; units updates on the clock after a tick.
// Backpressure: none; clr restarts both counters from zero on the next clock.
//
// Ports: clk, rst (sync, active-high), clr (restart timing), tick (prescaler wraps
// this cycle), units (completed units since last clear, saturates at 7).
module morse_receiver_unit_timer #(
  parameter int UNIT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic       tick,
  output logic [2:0] units
);

  localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  logic [PW-1:0] presc;

  assign tick = (presc == PW'(UNIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      presc <= '0;
      units <= '0;
    end else if (tick) begin
      presc <= '0;
      if (units != 3'd7) units <= units + 3'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/morse_receiver.sv
// Morse receiver: times key marks/spaces, classifies dot/dash and decodes letters A-H to a 3-bit index.
// Latency: valid_o/err_o pulse GAP_UNITS*UNIT_CYCLES+1 cycles after the synchronised key falls.
// Backpressure: none; the key is a free-running level and results are single-cycle pulses.
//
// Ports: CLOCK_50 clock; rst sync active-high reset; key_i raw key (1 = pressed);
// letter_o last good letter; valid_o/err_o one-cycle result pulses; sym_cnt_o
// symbols in the current letter; state_o FSM state for debug LEDs.
module morse_receiver
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 25_000_000,
  parameter int DASH_UNITS  = 2,
  parameter int GAP_UNITS   = 3
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       key_i,
  output logic [2:0] letter_o,
  output logic       valid_o,
  output logic       err_o,
  output logic [2:0] sym_cnt_o,
  output logic [1:0] state_o
);

  logic       key_m, key_s;
  state_t     state_q, state_d;
  logic [3:0] code_q, code_d;
  logic [2:0] sym_cnt_d;
  logic       ovf_q, ovf_d;
  logic [2:0] letter_d;
  logic       valid_d, err_d;
  logic       tick;
  logic [2:0] units;
  logic [2:0] units_now;
  logic       is_dash;
  logic [3:0] match;

  // Timing restarts on every state change so each mark/space is measured alone.
  morse_receiver_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk  (CLOCK_50),
    .rst  (rst),
    .clr  (state_d != state_q),
    .tick (tick),
    .units(units)
  );

  // Count the unit completing in this very cycle, so a mark or space of exactly
  // N units is judged as N units rather than N-1.
  assign units_now = (tick && units != 3'd7) ? units + 3'd1 : units;
  assign is_dash   = (units_now >= 3'(DASH_UNITS));
  assign match     = lookup_letter(sym_cnt_o, code_q);
  assign state_o   = state_q;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    sym_cnt_d = sym_cnt_o;
    ovf_d     = ovf_q;
    letter_d  = letter_o;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d   = MARK;
          code_d    = 4'b0000;
          sym_cnt_d = 3'd0;
          ovf_d     = 1'b0;
        end
      end
      MARK: begin
        if (!key_s) begin
          state_d = SPACE;
          if (sym_cnt_o < 3'(MAX_SYMS)) begin
            code_d    = code_q | ({3'b000, is_dash} << sym_cnt_o[1:0]);
            sym_cnt_d = sym_cnt_o + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      SPACE: begin
        // A press beats the gap threshold when both land in the same cycle.
        if (key_s) begin
          state_d = MARK;
        end else if (units_now >= 3'(GAP_UNITS)) begin
          state_d = DECODE;
          // Result registers load on entry, so the pulse is the DECODE cycle.
          if (match[3] && !ovf_q) begin
            letter_d = match[2:0];
            valid_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DECODE: begin
        state_d   = IDLE;
        sym_cnt_d = 3'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      key_m     <= 1'b0;
      key_s     <= 1'b0;
      state_q   <= IDLE;
      code_q    <= 4'b0000;
      sym_cnt_o <= 3'd0;
      ovf_q     <= 1'b0;
      letter_o  <= 3'd0;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      key_m     <= key_i;
      key_s     <= key_m;
      state_q   <= state_d;
      code_q    <= code_d;
      sym_cnt_o <= sym_cnt_d;
      ovf_q     <= ovf_d;
      letter_o  <= letter_d;
      valid_o   <= valid_d;
      err_o     <= err_d;
    end
  end

endmodule

// File: tb/tb_morse_receiver.sv
// Self-checking bench for morse_receiver: directed letters plus randomised letters vs a string-table model.
// Latency: n/a.
// Backpressure: n/a.
module tb_morse_receiver;

  localparam int UNIT = 4;
  localparam int DASH = 2;
  localparam int GAP  = 3;
  localparam int IDLE_GAP = GAP * UNIT + 8;
  localparam int PULSE_DLY = GAP * UNIT + 2;

  logic       CLOCK_50 = 1'b0;
  logic       rst = 1'b1;
  logic       key_i = 1'b0;
  logic [2:0] letter_o;
  logic       valid_o;
  logic       err_o;
  logic [2:0] sym_cnt_o;
  logic [1:0] state_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int mark_q[$];
  int space_q[$];
  int p_cyc[$];
  bit p_err[$];
  logic [2:0] p_let[$];
  bit both_seen = 1'b0;
  logic [2:0] exp_letter = 3'd0;
  string table_s[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

  morse_receiver #(
    .UNIT_CYCLES(UNIT),
    .DASH_UNITS (DASH),
    .GAP_UNITS  (GAP)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .key_i    (key_i),
    .letter_o (letter_o),
    .valid_o  (valid_o),
    .err_o    (err_o),
    .sym_cnt_o(sym_cnt_o),
    .state_o  (state_o)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Record every result pulse with the posedge count at which it became visible.
  always @(negedge CLOCK_50) begin
    if (valid_o === 1'b1 || err_o === 1'b1) begin
      p_cyc.push_back(cyc);
      p_err.push_back(err_o);
      p_let.push_back(letter_o);
    end
    if (valid_o === 1'b1 && err_o === 1'b1) both_seen = 1'b1;
  end

  task automatic clear_pulses();
    p_cyc.delete();
    p_err.delete();
    p_let.delete();
  endtask

  // Plays mark_q/space_q on the key (starting at a negedge) then idles long enough to end the letter.
  task automatic play();
    for (int i = 0; i < mark_q.size(); i++) begin
      key_i = 1'b1;
      repeat (mark_q[i]) @(negedge CLOCK_50);
      key_i = 1'b0;
      fall_cyc = cyc + 1;
      if (i < mark_q.size() - 1) repeat (space_q[i]) @(negedge CLOCK_50);
    end
    repeat (IDLE_GAP) @(negedge CLOCK_50);
  endtask

  // Expected letter index from the mark lengths, or -1 for a rejected letter.
  function automatic int model_letter();
    string pat;
    pat = "";
    if (mark_q.size() > 4) return -1;
    foreach (mark_q[i]) begin
      if (mark_q[i] / UNIT >= DASH) pat = {pat, "-"};
      else pat = {pat, "."};
    end
    for (int k = 0; k < 8; k++) if (table_s[k] == pat) return k;
    return -1;
  endfunction

  task automatic test_reset();
    key_i = 1'b1;
    @(negedge CLOCK_50);
    key_i = 1'b0;
    @(negedge CLOCK_50);
    tests++;
    if ({letter_o, valid_o, err_o, sym_cnt_o, state_o} !== 10'd0) begin
      fails++;
      $display("FAIL reset_outputs got letter=%0d valid=%0b err=%0b sym=%0d state=%0d want all 0",
               letter_o, valid_o, err_o, sym_cnt_o, state_o);
    end
    rst = 1'b0;
    clear_pulses();
    repeat (20) @(negedge CLOCK_50);
    tests++;
    if (p_cyc.size() != 0 || state_o !== 2'd0) begin
      fails++;
      $display("FAIL reset_quiet got pulses=%0d state=%0d want 0 0", p_cyc.size(), state_o);
    end
  endtask

  task automatic test_letter_a();
    mark_q = '{4, 12};
    space_q = '{4};
    clear_pulses();
    play();
    tests++;
    if (p_cyc.size() != 1) begin
      fails++;
      $display("FAIL A_count got %0d pulses want 1", p_cyc.size());
    end else begin
      tests++;
      if (p_err[0] !== 1'b0 || p_let[0] !== 3'd0) begin
        fails++;
        $display("FAIL A_result got err=%0b letter=%0d want err=0 letter=0", p_err[0], p_let[0]);
      end
      tests++;
      if (p_cyc[0] != fall_cyc + 14) begin
        fails++;
        $display("FAIL A_timing got cycle %0d want %0d", p_cyc[0], fall_cyc + 14);
      end
    end
    exp_letter = 3'd0;
  endtask

  task automatic test_letter_h();
    clear_pulses();
    for (int i = 0; i < 4; i++) begin
      key_i = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      key_i = 1'b0;
      repeat ((i < 3) ? 4 : 3) @(negedge CLOCK_50);
      tests++;
      if (sym_cnt_o !== 3'(i + 1)) begin
        fails++;
        $display("FAIL H_symcnt%0d got %0d want %0d", i, sym_cnt_o, i + 1);
      end
    end
    repeat (IDLE_GAP) @(negedge CLOCK_50);
    tests++;
    if (p_cyc.size() != 1 || p_err[0] !== 1'b0 || p_let[0] !== 3'd7) begin
      fails++;
      $display("FAIL H_result got pulses=%0d letter=%0d want one valid letter=7", p_cyc.size(), letter_o);
    end
    tests++;
    if (sym_cnt_o !== 3'd0 || state_o !== 2'd0) begin
      fails++;
      $display("FAIL H_after got sym=%0d state=%0d want 0 0", sym_cnt_o, state_o);
    end
    exp_letter = 3'd7;
  endtask

  task automatic test_overflow();
    mark_q = '{2, 2, 2, 2, 2};
    space_q = '{2, 2, 2, 2};
    clear_pulses();
    play();
    tests++;
    if (p_cyc.size() != 1 || p_err[0] !== 1'b1) begin
      fails++;
      $display("FAIL ovf_err got pulses=%0d want exactly one err pulse", p_cyc.size());
    end
    tests++;
    if (letter_o !== 3'd7) begin
      fails++;
      $display("FAIL ovf_letter got %0d want 7", letter_o);
    end
  endtask

  task automatic test_no_match_then_e();
    mark_q = '{9, 10, 11, 12};
    space_q = '{3, 3, 3};
    clear_pulses();
    play();
    tests++;
    if (p_cyc.size() != 1 || p_err[0] !== 1'b1 || letter_o !== 3'd7) begin
      fails++;
      $display("FAIL nomatch got pulses=%0d letter=%0d want one err letter=7", p_cyc.size(), letter_o);
    end
    mark_q = '{2};
    space_q.delete();
    clear_pulses();
    play();
    tests++;
    if (p_cyc.size() != 1 || p_err[0] !== 1'b0 || p_let[0] !== 3'd4) begin
      fails++;
      $display("FAIL E_result got pulses=%0d letter=%0d want one valid letter=4", p_cyc.size(), letter_o);
    end
    exp_letter = 3'd4;
  endtask

  task automatic test_reset_mid_mark();
    clear_pulses();
    key_i = 1'b1;
    repeat (12) @(negedge CLOCK_50);
    key_i = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    key_i = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    rst = 1'b1;
    key_i = 1'b0;
    @(negedge CLOCK_50);
    tests++;
    if (state_o !== 2'd0 || sym_cnt_o !== 3'd0) begin
      fails++;
      $display("FAIL rstmid_state got state=%0d sym=%0d want 0 0", state_o, sym_cnt_o);
    end
    @(negedge CLOCK_50);
    rst = 1'b0;
    repeat (IDLE_GAP) @(negedge CLOCK_50);
    tests++;
    if (p_cyc.size() != 0) begin
      fails++;
      $display("FAIL rstmid_pulse got %0d pulses want 0", p_cyc.size());
    end
    exp_letter = 3'd0;
    mark_q = '{8, 8, 4};
    space_q = '{5, 5};
    clear_pulses();
    play();
    tests++;
    if (p_cyc.size() != 1 || p_err[0] !== 1'b0 || p_let[0] !== 3'd6) begin
      fails++;
      $display("FAIL G_result got pulses=%0d letter=%0d want one valid letter=6", p_cyc.size(), letter_o);
    end
    exp_letter = 3'd6;
  endtask

  task automatic test_random();
    int n;
    int exp;
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 5);
      mark_q.delete();
      space_q.delete();
      for (int i = 0; i < n; i++) begin
        mark_q.push_back($urandom_range(1, 20));
        if (i < n - 1) space_q.push_back($urandom_range(1, GAP * UNIT));
      end
      exp = model_letter();
      clear_pulses();
      play();
      tests++;
      if (p_cyc.size() != 1) begin
        fails++;
        $display("FAIL rand%0d_count got %0d pulses want 1", t, p_cyc.size());
      end else begin
        tests++;
        if (p_err[0] !== (exp < 0)) begin
          fails++;
          $display("FAIL rand%0d_kind got err=%0b want err=%0b", t, p_err[0], exp < 0);
        end
        tests++;
        if (p_cyc[0] != fall_cyc + PULSE_DLY) begin
          fails++;
          $display("FAIL rand%0d_timing got cycle %0d want %0d", t, p_cyc[0], fall_cyc + PULSE_DLY);
        end
      end
      if (exp >= 0) exp_letter = 3'(exp);
      tests++;
      if (letter_o !== exp_letter) begin
        fails++;
        $display("FAIL rand%0d_letter got %0d want %0d", t, letter_o, exp_letter);
      end
    end
  endtask

  task automatic test_exclusive();
    tests++;
    if (both_seen) begin
      fails++;
      $display("FAIL exclusive got valid and err together want never");
    end
  endtask

  initial begin
    @(negedge CLOCK_50);
    test_reset();
    test_letter_a();
    test_letter_h();
    test_overflow();
    test_no_match_then_e();
    test_reset_mid_mark();
    test_random();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/morse_receiver.md
Name: morse_receiver

Overview:
- Receive side of the Morse lab link. Samples a single hand key, measures mark and space durations in time units, and classifies each mark as dot or dash.
- Assembles up to 4 symbols and decodes the completed letter to the 3-bit A–H index used on the transmit side (SW[2:0] encoding).
- Top level drives key_i from an inverted KEY[1] and shows letter_o/flags on LEDR.

Parameters:
- UNIT_CYCLES, 25_000_000, clock cycles per time unit (0.5 s at 50 MHz); bench uses 4.
- DASH_UNITS, 2, mark of >= DASH_UNITS completed units is a dash, else a dot.
- GAP_UNITS, 3, completed units of continuous space that end a letter.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- key_i  in  1  asynchronous key level, 1 = pressed.
- letter_o  out  3  last decoded letter index, A=0 … H=7; holds until next valid decode.
- valid_o  out  1  one-cycle pulse when letter_o updates.
- err_o  out  1  one-cycle pulse when a letter is rejected (more than 4 symbols, or no table match).
- sym_cnt_o  out  3  symbols captured in the current letter, 0..4.
- state_o  out  2  FSM state encoding, for LED debug.

Behaviour:
- Reset: state IDLE. letter_o, valid_o, err_o, sym_cnt_o = 0. Code register, overflow flag, prescaler, unit counter and synchronizer flops cleared. rst wins over every other event, including mid-MARK and mid-SPACE; a partial letter is discarded with no pulse.
- Synchronizer: key_i passes 2 flops to key_s. All timing is relative to key_s, which lags key_i by 2 cycles.
- Timing: prescaler counts 0..UNIT_CYCLES-1. It is cleared on every FSM state change. Each wrap increments units. units is 3 bits and saturates at 7.
- States: IDLE=0, MARK=1, SPACE=2, DECODE=3.
- IDLE: key_s=1 -> MARK; clear code register, sym_cnt_o and overflow flag.
- MARK: when key_s=0, classify the mark (units < DASH_UNITS gives dot=0, otherwise dash=1).
  - If sym_cnt_o < 4: write the symbol to code[sym_cnt_o] and increment sym_cnt_o.
  - Else: set the overflow flag and leave code unchanged.
  - Next state is SPACE.
  - Any key_s high pulse of >= 1 cycle counts as a dot; there is no debounce in this block.
- SPACE:
  - key_s=1 -> MARK (next symbol of the same letter).
  - Else, on the cycle units reaches GAP_UNITS -> DECODE.
  - If key_s=1 and the gap threshold occur in the same cycle, key_s wins and the letter continues.
- DECODE: one cycle, then always -> IDLE. key_s is ignored during this cycle; a press held over into IDLE starts a new letter.
  - Match {sym_cnt_o, code} against the table.
  - Hit with overflow clear: letter_o <= index, valid_o=1.
  - Otherwise: err_o=1 and letter_o is unchanged.
  - sym_cnt_o clears on entry to IDLE.
- Pulse timing: valid_o/err_o are registered and high for exactly 1 cycle. That cycle is GAP_UNITS*UNIT_CYCLES + 1 cycles after the cycle key_s falls, i.e. 2 more cycles after key_i falls.
- valid_o and err_o are never high together.
- Code table, symbol 0 = first received, 0 = dot, 1 = dash:
  - A len2 .-
  - B len4 -...
  - C len4 -.-.
  - D len3 -..
  - E len1 .
  - F len4 ..-.
  - G len3 --.
  - H len4 ....

Decomposition:
- Package morse_pkg holds:
  - state_t enum (IDLE, MARK, SPACE, DECODE, 2 bits).
  - MAX_SYMS=4.
  - The 8-entry letter table as constants {len[2:0], code[3:0]}, shared with the transmit-side decoder table.
- One natural sub-module: unit_timer, containing the prescaler and saturating unit counter with clear and tick outputs.
- The decode lookup is a combinational function in the package.

Test Plan (UNIT_CYCLES=4, DASH_UNITS=2, GAP_UNITS=3):
1. Assert rst for 2 cycles with key_i toggling -> all outputs 0, state_o=0; no pulses for 20 cycles after release with key_i=0.
2. Send A: key_i high 4 cycles, low 4, high 12, then low -> exactly one valid_o pulse 14 cycles after the final key_i fall; letter_o=0, err_o never high.
3. Send H: four 3-cycle presses separated by 4-cycle gaps, then idle -> valid_o once, letter_o=7, sym_cnt_o steps 1,2,3,4 then back to 0.
4. Send five dots -> err_o one pulse, no valid_o, letter_o keeps previous value (7).
5. Send dash ×4 ("----", not in table) -> err_o pulse, letter_o unchanged. Then send E (one 2-cycle press) -> valid_o with letter_o=4.
6. Assert rst during the MARK of the second symbol of B -> state_o=0 next cycle, no valid_o or err_o. Then send G cleanly -> letter_o=6.
